laplace_aproximado_v2: RTL and testbench



---
 rtl/laplace_aproximado_v2_pkg.sv | 32 +++
 rtl/laplace_aproximado_v2_loa.sv | 36 +++
 rtl/laplace_aproximado_v2.sv | 88 ++++++++
 tb/tb_laplace_aproximado_v2.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/laplace_aproximado_v2_pkg.sv
// ---------------------------------------------------------------------------
// laplace_pkg
// Shared widths, bounds and helpers for the approximate 4-neighbour Laplacian
// kernel.
//   PIX_W    : pixel width
//   SUM_W    : width of the four-neighbour sum (PIX_W + 2)
//   DIFF_W   : width of the signed centre-minus-sum difference (PIX_W + 3)
//   OUT_W    : width of the saturated output (PIX_W + 1)
//   OUT_MAX  : largest value the output can hold
// ---------------------------------------------------------------------------
package laplace_pkg;

  localparam int PIX_W   = 8;
  localparam int SUM_W   = PIX_W + 2;
  localparam int DIFF_W  = PIX_W + 3;
  localparam int OUT_W   = PIX_W + 1;
  localparam int OUT_MAX = 511;

  // Clamp a signed difference into the unsigned output range [0, OUT_MAX].
  function automatic logic [OUT_W-1:0] sat_out(input logic signed [DIFF_W-1:0] diff);
    logic [OUT_W-1:0] res;
    if (diff[DIFF_W-1]) begin
      res = {OUT_W{1'b0}};
    end else if (diff > $signed(DIFF_W'(OUT_MAX))) begin
      res = OUT_W'(OUT_MAX);
    end else begin
      res = diff[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/laplace_aproximado_v2_loa.sv
// ---------------------------------------------------------------------------
// loa_adder
// Lower-part-OR approximate adder. The low K bits are formed by OR-ing the
// operands; the upper part is an exact adder whose carry-in is the AND of
// the top approximate bit pair. K = 0 degenerates to an exact adder.
//   x_i, y_i : W-bit unsigned operands
//   r_o      : W+1-bit result
// Parameters: W (operand width), K (approximate low bits, 0 <= K < W).
// ---------------------------------------------------------------------------
module loa_adder #(
  parameter int W = 8,
  parameter int K = 2
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W:0]   r_o
);

  generate
    if (K == 0) begin : g_exact
      assign r_o = {1'b0, x_i} + {1'b0, y_i};
    end else begin : g_loa
      logic [K-1:0] low_s;
      logic         carry_s;
      logic [W-K:0] high_s;

      // Low part is OR only; the top OR'd pair still predicts the carry upward.
      assign low_s   = x_i[K-1:0] | y_i[K-1:0];
      assign carry_s = x_i[K-1] & y_i[K-1];
      assign high_s  = {1'b0, x_i[W-1:K]} + {1'b0, y_i[W-1:K]}
                     + {{(W-K){1'b0}}, carry_s};
      assign r_o     = {high_s, low_s};
    end
  endgenerate

endmodule

// File: rtl/laplace_aproximado_v2.sv
// ---------------------------------------------------------------------------
// laplace_aproximado_v2
// Registered approximate 4-neighbour Laplacian: s = clamp(4*e - (b+d+f+h)),
// with the neighbour sum built from a tree of lower-part-OR adders.
// One result per clock, latency one cycle, no backpressure.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset (clears s and out_valid)
//   in_valid  : b/d/e/f/h valid this cycle
//   b,d,e,f,h : north, west, centre, east, south pixels (unsigned)
//   out_valid : s holds a fresh result
//   s         : filtered value clamped to 0..511; s holds when idle
// Parameters: APPROX_BITS (OR-ed low bits per adder, 0..7), PIX_W.
// ---------------------------------------------------------------------------
module laplace_aproximado_v2
  import laplace_pkg::*;
#(
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] d,
  input  logic [PIX_W-1:0] e,
  input  logic [PIX_W-1:0] f,
  input  logic [PIX_W-1:0] h,
  output logic             out_valid,
  output logic [OUT_W-1:0] s
);

  logic [PIX_W:0]         p1_s;
  logic [PIX_W:0]         p2_s;
  logic [SUM_W-1:0]       sum_s;
  logic [SUM_W-1:0]       centre_s;
  logic signed [DIFF_W-1:0] diff_s;
  logic [OUT_W-1:0]       s_d;
  logic [OUT_W-1:0]       s_q;
  logic                   valid_d;
  logic                   valid_q;

  loa_adder #(.W(PIX_W), .K(APPROX_BITS)) u_loa_bd (
    .x_i (b),
    .y_i (d),
    .r_o (p1_s)
  );

  loa_adder #(.W(PIX_W), .K(APPROX_BITS)) u_loa_fh (
    .x_i (f),
    .y_i (h),
    .r_o (p2_s)
  );

  loa_adder #(.W(PIX_W + 1), .K(APPROX_BITS)) u_loa_sum (
    .x_i (p1_s),
    .y_i (p2_s),
    .r_o (sum_s)
  );

  // Exact centre term and signed difference; both operands zero-extended.
  assign centre_s = {e, 2'b00};
  assign diff_s   = $signed({1'b0, centre_s}) - $signed({1'b0, sum_s});

  // Next-state: capture a clamped result on valid input, otherwise hold s.
  always_comb begin
    s_d     = s_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d = sat_out(diff_s);
    end else begin
      s_d = s_q;
    end
  end

  // Output register; reset dominates any sample presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= {OUT_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign s         = s_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_laplace_aproximado_v2.sv
module tb_laplace_aproximado_v2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] b, d, e, f, h;
  logic       out_valid_a, out_valid_x;
  logic [8:0] s_a, s_x;

  int checks_q;
  int errors_q;

  // DUT with the default two approximate bits
  laplace_aproximado_v2 #(.APPROX_BITS(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .b         (b),
    .d         (d),
    .e         (e),
    .f         (f),
    .h         (h),
    .out_valid (out_valid_a),
    .s         (s_a)
  );

  // Exact reference configuration
  laplace_aproximado_v2 #(.APPROX_BITS(0)) u_dut_x (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .b         (b),
    .d         (d),
    .e         (e),
    .f         (f),
    .h         (h),
    .out_valid (out_valid_x),
    .s         (s_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks_q = checks_q + 1;
    if (obs !== exp) begin
      errors_q = errors_q + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int vb, input int vd, input int ve,
                       input int vf, input int vh);
    in_valid = v;
    b = vb[7:0];
    d = vd[7:0];
    e = ve[7:0];
    f = vf[7:0];
    h = vh[7:0];
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_q = 0;
    errors_q = 0;
    rst_n = 1'b0;
    drive(1'b1, 0, 0, 255, 0, 0);

    // 1. reset holds outputs clear even with a valid sample
    tick();
    chk("rst_valid_0", int'(out_valid_a), 0);
    chk("rst_s_0", int'(s_a), 0);
    tick();
    chk("rst_valid_1", int'(out_valid_a), 0);
    chk("rst_s_1", int'(s_a), 0);
    chk("rst_s_exact", int'(s_x), 0);
    rst_n = 1'b1;
    tick();
    chk("first_valid", int'(out_valid_a), 1);
    chk("first_s", int'(s_a), 511);

    // 2. flat region
    drive(1'b1, 100, 100, 100, 100, 100);
    tick();
    chk("flat_s", int'(s_a), 0);
    chk("flat_valid", int'(out_valid_a), 1);

    // 4. negative clamps
    drive(1'b1, 255, 255, 0, 255, 255);
    tick();
    chk("neg_all255", int'(s_a), 0);
    chk("neg_all255_x", int'(s_x), 0);

    // 5. approximation visible: LOA(3,1)=3
    drive(1'b1, 3, 1, 10, 0, 0);
    tick();
    chk("approx_k2", int'(s_a), 37);
    chk("approx_k0", int'(s_x), 36);

    // carry out of the OR region: LOA(3,3)=7
    drive(1'b1, 3, 3, 5, 0, 0);
    tick();
    chk("carry_k2", int'(s_a), 13);
    chk("carry_k0", int'(s_x), 14);

    // every neighbour contributes through the tree
    drive(1'b1, 1, 1, 60, 1, 1);
    tick();
    chk("ones_k2", int'(s_a), 239);
    chk("ones_k0", int'(s_x), 236);

    // hold: idle cycle keeps last value
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    chk("hold_valid", int'(out_valid_a), 0);
    chk("hold_s", int'(s_a), 239);

    // 6. streaming three back-to-back samples
    drive(1'b1, 3, 1, 10, 0, 0);
    tick();
    chk("stream0_s", int'(s_a), 37);
    chk("stream0_v", int'(out_valid_a), 1);
    drive(1'b1, 0, 0, 255, 0, 0);
    tick();
    chk("stream1_s", int'(s_a), 511);
    chk("stream1_v", int'(out_valid_a), 1);
    drive(1'b1, 50, 0, 0, 0, 0);
    tick();
    chk("stream2_s", int'(s_a), 0);
    chk("stream2_v", int'(out_valid_a), 1);
    drive(1'b0, 0, 0, 255, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_v", int'(out_valid_a), 0);
      chk("idle_s", int'(s_a), 0);
    end

    // mid-stream reset drops the sample in flight
    drive(1'b1, 3, 1, 10, 0, 0);
    tick();
    chk("pre_rst_s", int'(s_a), 37);
    rst_n = 1'b0;
    drive(1'b1, 0, 0, 255, 0, 0);
    tick();
    chk("mid_rst_v", int'(out_valid_a), 0);
    chk("mid_rst_s", int'(s_a), 0);
    rst_n = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    chk("post_rst_v", int'(out_valid_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
